melody_sequencer: RTL and testbench
===================================

MELODY_SEQUENCER -- requirements
Module: melody_sequencer

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BEAT_TICKS, default 12_500_000, clock cycles per beat (1 to 2^24-1).
REQ-003 Parameter SEQ_LEN, default 16, number of melody ROM entries (power of two, max 16).
REQ-004 clock  in  1  system clock, rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to begin playback from entry 0.
REQ-007 stop  in  1  one-cycle request to abort playback.
REQ-008 loop_en  in  1  when high, the sequence wraps to entry 0 instead of finishing.
REQ-009 cfg_ready  in  1  tone generator accepts a configuration.
REQ-010 cfg_valid  out  1  configuration offered to the tone generator.
REQ-011 cfg_period  out  18  half-period count for the tone generator.
REQ-012 cfg_rest  out  1  current entry is a rest (silence).
REQ-013 tone_en  out  1  tone generator output enable.
REQ-014 note_idx  out  4  current ROM address.
REQ-015 busy  out  1  playback in progress.
REQ-016 done  out  1  one-cycle pulse at the end of a non-looping sequence.
REQ-017 led  out  10  bits [6:0] one-hot sounding note, bit 9 = busy, bits 8:7 = 0.

Function
REQ-018 The ROM entry SHALL be 7 bits: [6:4] note code (0..6 = C D E F G A B at 523/587/659/698/783/880/987 Hz; 7 = rest), [3:0] beats; beats==0 SHALL be the end marker.
REQ-019 Default ROM contents SHALL be: entries 0-6 = notes 0-6 at 4 beats each; entry 7 = rest at 2 beats; entries 8-15 = end marker.
REQ-020 cfg_period SHALL be CLK_HZ/(2*freq), truncated, taken from a 7-entry constant table (C = 95602); it SHALL be 0 for a rest.
REQ-021 FSM states SHALL be IDLE, LOAD, CFG, PLAY.
REQ-022 IDLE: on start (and not stop), go to LOAD with note_idx=0. start while busy SHALL be ignored.
REQ-023 LOAD (1 cycle): latch the entry. If end marker: with loop_en=1, set note_idx=0 and stay in LOAD; with loop_en=0, pulse done and go to IDLE. Otherwise go to CFG.
REQ-024 CFG: cfg_valid=1, and cfg_period and cfg_rest SHALL be held stable. On cfg_valid && cfg_ready, go to PLAY and clear the prescaler and beat counters.
REQ-025 PLAY: the prescaler counts 0..BEAT_TICKS-1. Each wrap increments the beat count. After the last beat, note_idx SHALL advance and the FSM SHALL return to LOAD.
REQ-026 When note_idx==SEQ_LEN-1 finishes, the sequence SHALL be treated as an end marker (REQ-023 rules, applied directly without a LOAD).
REQ-027 tone_en SHALL be 1 only in PLAY with cfg_rest=0. led[6:0] SHALL follow the same condition.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 stop SHALL have priority in every state. The next cycle SHALL be IDLE with cfg_valid=0, tone_en=0 and no done pulse. Abandoning an unaccepted cfg_valid is permitted.
REQ-030 When start and stop arrive in the same cycle, the FSM SHALL stay in IDLE.
REQ-031 Prescaler SHALL be 24 bits and beat counter 4 bits; neither SHALL count outside PLAY.

Reset
REQ-032 While resetn=0: state=IDLE, note_idx=0, all counters=0, and cfg_valid, cfg_rest, tone_en, busy, done = 0.
REQ-033 While resetn=0: cfg_period=0 and led=0.
REQ-034 Reset mid-playback SHALL take effect asynchronously. Release SHALL leave the block in IDLE awaiting start.

Structure
REQ-035 Note codes, the rest code, the frequency table and the ROM entry width SHALL live in a shared package (melody_pkg). The existing tone path SHALL reuse the same note codes.
REQ-036 The ROM SHALL be a separate sub-module, melody_rom: combinational, address in, 7-bit entry out.

Verification (BEAT_TICKS=4)
REQ-037 Reset: assert resetn=0 mid-PLAY -> all outputs 0 immediately; after release, the FSM is IDLE.
REQ-038 start at cycle t with cfg_ready=1 -> cfg_valid=1 and cfg_period=95602 at t+2; tone_en=1 and led=0x201 from t+3 for 16 cycles; then note_idx=1 and cfg_period=85178.
REQ-039 cfg_ready=0 for 10 cycles in CFG -> cfg_valid and cfg_period stay stable; tone_en=0; no beat counted.
REQ-040 Entry 7 (rest) -> cfg_rest=1, cfg_period=0, tone_en=0 for 8 cycles.
REQ-041 End marker with loop_en=0 -> done high exactly 1 cycle and busy=0. With loop_en=1 -> note_idx=0, no done, and C replays.
REQ-042 stop during PLAY of entry 3 -> next cycle tone_en=0, led=0, busy=0; a later start restarts at note_idx=0.

Source files
------------

// File: rtl/melody_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// melody_pkg : note codes, frequency table and ROM entry layout for the melody
// sequencer and tone path.  Rev 1.0
// ----------------------------------------------------------------------------
package melody_pkg;

  localparam int ENTRY_W  = 7;
  localparam int NOTE_W   = 3;
  localparam int BEATS_W  = 4;
  localparam int PERIOD_W = 18;

  typedef enum logic [NOTE_W-1:0] {
    NOTE_C    = 3'd0,
    NOTE_D    = 3'd1,
    NOTE_E    = 3'd2,
    NOTE_F    = 3'd3,
    NOTE_G    = 3'd4,
    NOTE_A    = 3'd5,
    NOTE_B    = 3'd6,
    NOTE_REST = 3'd7
  } note_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CFG  = 2'd2,
    ST_PLAY = 2'd3
  } state_t;

  typedef struct packed {
    logic [NOTE_W-1:0]  note;
    logic [BEATS_W-1:0] beats;
  } entry_t;

  // Rest returns 1 Hz so constant period arithmetic never divides by zero.
  function automatic int unsigned note_freq_hz(input int unsigned code);
    case (code)
      0:       return 523;
      1:       return 587;
      2:       return 659;
      3:       return 698;
      4:       return 783;
      5:       return 880;
      6:       return 987;
      default: return 1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/melody_rom.sv
`default_nettype none
// ----------------------------------------------------------------------------
// melody_rom : combinational melody table, address in, 7-bit entry out.
// Rev 1.0
// ----------------------------------------------------------------------------
module melody_rom
  import melody_pkg::*;
#(
  parameter int unsigned SEQ_LEN = 16
) (
  input  logic [3:0]         addr_i,
  output logic [ENTRY_W-1:0] entry_o
);

  always_comb begin
    entry_o = '0;
    if (32'(addr_i) < SEQ_LEN) begin
      case (addr_i)
        4'd0:    entry_o = {NOTE_C,    4'd4};
        4'd1:    entry_o = {NOTE_D,    4'd4};
        4'd2:    entry_o = {NOTE_E,    4'd4};
        4'd3:    entry_o = {NOTE_F,    4'd4};
        4'd4:    entry_o = {NOTE_G,    4'd4};
        4'd5:    entry_o = {NOTE_A,    4'd4};
        4'd6:    entry_o = {NOTE_B,    4'd4};
        4'd7:    entry_o = {NOTE_REST, 4'd2};
        default: entry_o = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/melody_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// melody_sequencer : steps through the melody ROM, hands each note to the tone
// generator over a valid/ready handshake and times it in beats.  Rev 1.0
// ----------------------------------------------------------------------------
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BEAT_TICKS = 12_500_000,
  parameter int unsigned SEQ_LEN    = 16
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  input  logic                stop,
  input  logic                loop_en,
  input  logic                cfg_ready,
  output logic                cfg_valid,
  output logic [PERIOD_W-1:0] cfg_period,
  output logic                cfg_rest,
  output logic                tone_en,
  output logic [3:0]          note_idx,
  output logic                busy,
  output logic                done,
  output logic [9:0]          led
);

  localparam logic [23:0] LAST_TICK = 24'(BEAT_TICKS - 1);
  localparam logic [3:0]  LAST_IDX  = 4'(SEQ_LEN - 1);

  state_t                state_q;
  logic [3:0]            note_idx_q;
  logic [23:0]           presc_q;
  logic [BEATS_W-1:0]    beat_q;
  logic [BEATS_W-1:0]    beats_q;
  logic [NOTE_W-1:0]     code_q;
  logic                  cfg_valid_q;
  logic [PERIOD_W-1:0]   cfg_period_q;
  logic                  cfg_rest_q;
  logic                  tone_en_q;
  logic                  busy_q;
  logic                  done_q;

  entry_t                rom_entry;
  logic [PERIOD_W-1:0]   period_tab [8];

  melody_rom #(
    .SEQ_LEN (SEQ_LEN)
  ) u_rom (
    .addr_i  (note_idx_q),
    .entry_o (rom_entry)
  );

  // Half-period table is folded to constants at elaboration.
  for (genvar gi = 0; gi < 8; gi++) begin : g_period
    if (gi == 32'(NOTE_REST)) begin : g_rest
      assign period_tab[gi] = '0;
    end else begin : g_tone
      assign period_tab[gi] = PERIOD_W'(CLK_HZ / (2 * note_freq_hz(gi)));
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      note_idx_q   <= '0;
      presc_q      <= '0;
      beat_q       <= '0;
      beats_q      <= '0;
      code_q       <= '0;
      cfg_valid_q  <= 1'b0;
      cfg_period_q <= '0;
      cfg_rest_q   <= 1'b0;
      tone_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (stop) begin
        state_q     <= ST_IDLE;
        cfg_valid_q <= 1'b0;
        tone_en_q   <= 1'b0;
        busy_q      <= 1'b0;
        presc_q     <= '0;
        beat_q      <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              state_q    <= ST_LOAD;
              note_idx_q <= '0;
              busy_q     <= 1'b1;
            end
          end
          ST_LOAD: begin
            code_q  <= rom_entry.note;
            beats_q <= rom_entry.beats;
            if (rom_entry.beats == '0) begin
              if (loop_en) begin
                note_idx_q <= '0;
              end else begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              state_q      <= ST_CFG;
              cfg_valid_q  <= 1'b1;
              cfg_rest_q   <= (rom_entry.note == NOTE_REST);
              cfg_period_q <= period_tab[rom_entry.note];
            end
          end
          ST_CFG: begin
            if (cfg_ready) begin
              state_q     <= ST_PLAY;
              cfg_valid_q <= 1'b0;
              presc_q     <= '0;
              beat_q      <= '0;
              tone_en_q   <= ~cfg_rest_q;
            end
          end
          ST_PLAY: begin
            if (presc_q == LAST_TICK) begin
              presc_q <= '0;
              if (beat_q == beats_q - 4'd1) begin
                beat_q    <= '0;
                tone_en_q <= 1'b0;
                // The final ROM slot behaves like an end marker without a LOAD.
                if (note_idx_q == LAST_IDX) begin
                  if (loop_en) begin
                    note_idx_q <= '0;
                    state_q    <= ST_LOAD;
                  end else begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                  end
                end else begin
                  note_idx_q <= note_idx_q + 4'd1;
                  state_q    <= ST_LOAD;
                end
              end else begin
                beat_q <= beat_q + 4'd1;
              end
            end else begin
              presc_q <= presc_q + 24'd1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign cfg_valid  = cfg_valid_q;
  assign cfg_period = cfg_period_q;
  assign cfg_rest   = cfg_rest_q;
  assign tone_en    = tone_en_q;
  assign note_idx   = note_idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign led        = {busy_q, 2'b00, tone_en_q ? 7'(7'd1 << code_q) : 7'd0};

endmodule
`default_nettype wire

// File: tb/tb_melody_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_melody_sequencer : directed vector bench for melody_sequencer with
// BEAT_TICKS=4 (16 clocks per 4-beat note).  Rev 1.0
// ----------------------------------------------------------------------------
module tb_melody_sequencer;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic        cfg_ready = 1'b1;
  logic        cfg_valid;
  logic [17:0] cfg_period;
  logic        cfg_rest;
  logic        tone_en;
  logic [3:0]  note_idx;
  logic        busy;
  logic        done;
  logic [9:0]  led;

  logic [36:0] act;
  assign act = {cfg_valid, cfg_period, cfg_rest, tone_en, note_idx, busy, done, led};

  melody_sequencer #(
    .CLK_HZ     (100_000_000),
    .BEAT_TICKS (4),
    .SEQ_LEN    (16)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .stop       (stop),
    .loop_en    (loop_en),
    .cfg_ready  (cfg_ready),
    .cfg_valid  (cfg_valid),
    .cfg_period (cfg_period),
    .cfg_rest   (cfg_rest),
    .tone_en    (tone_en),
    .note_idx   (note_idx),
    .busy       (busy),
    .done       (done),
    .led        (led)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        st;
    logic        sp;
    logic        lp;
    logic        rdy;
    int          adv;
    logic [36:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   te_cnt;

  function automatic logic [36:0] pk(input logic cv, input logic [17:0] per,
                                     input logic rest, input logic te,
                                     input logic [3:0] idx, input logic bz,
                                     input logic dn, input logic [9:0] ld);
    return {cv, per, rest, te, idx, bz, dn, ld};
  endfunction

  task automatic add(input logic st, input logic sp, input logic lp, input logic rdy,
                     input int adv, input logic [36:0] exp);
    vec_t v;
    v.st = st; v.sp = sp; v.lp = lp; v.rdy = rdy; v.adv = adv; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [36:0] got, input logic [36:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got {vld,per,rest,te,idx,busy,done,led}=%h required %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Playback with loop_en=0; comments give edges counted from the start edge E0
    add(1,0,0,1,  1, pk(0, 18'd0,     0,0,4'd0,1,0,10'h200)); // E0 LOAD
    add(0,0,0,1,  1, pk(1, 18'd95602, 0,0,4'd0,1,0,10'h200)); // E1 CFG C
    add(0,0,0,1,  1, pk(0, 18'd95602, 0,1,4'd0,1,0,10'h201)); // E2 PLAY C
    add(1,0,0,1, 15, pk(0, 18'd95602, 0,1,4'd0,1,0,10'h201)); // E17 busy start ignored
    add(0,0,0,1,  1, pk(0, 18'd95602, 0,0,4'd1,1,0,10'h200)); // E18 LOAD 1
    add(0,0,0,1,  1, pk(1, 18'd85178, 0,0,4'd1,1,0,10'h200)); // E19 CFG D
    add(0,0,0,1, 19, pk(0, 18'd75872, 0,1,4'd2,1,0,10'h204)); // E38 PLAY E
    add(0,0,0,1, 17, pk(1, 18'd71633, 0,0,4'd3,1,0,10'h200)); // E55 CFG F
    add(0,0,0,1, 18, pk(1, 18'd63856, 0,0,4'd4,1,0,10'h200)); // E73 CFG G
    add(0,0,0,1,  2, pk(0, 18'd63856, 0,1,4'd4,1,0,10'h210)); // E75 PLAY G
    add(0,0,0,1, 16, pk(1, 18'd56818, 0,0,4'd5,1,0,10'h200)); // E91 CFG A
    add(0,0,0,1, 18, pk(1, 18'd50658, 0,0,4'd6,1,0,10'h200)); // E109 CFG B
    add(0,0,0,1,  1, pk(0, 18'd50658, 0,1,4'd6,1,0,10'h240)); // E110 PLAY B
    add(0,0,0,1, 16, pk(0, 18'd50658, 0,0,4'd7,1,0,10'h200)); // E126 LOAD rest
    add(0,0,0,1,  1, pk(1, 18'd0,     1,0,4'd7,1,0,10'h200)); // E127 CFG rest
    add(0,0,0,1,  1, pk(0, 18'd0,     1,0,4'd7,1,0,10'h200)); // E128 PLAY rest
    add(0,0,0,1,  7, pk(0, 18'd0,     1,0,4'd7,1,0,10'h200)); // E135 last rest cycle
    add(0,0,0,1,  1, pk(0, 18'd0,     1,0,4'd8,1,0,10'h200)); // E136 LOAD end marker
    add(0,0,0,1,  1, pk(0, 18'd0,     1,0,4'd8,0,1,10'h000)); // E137 done pulse
    add(0,0,0,1,  1, pk(0, 18'd0,     1,0,4'd8,0,0,10'h000)); // E138 done cleared
    // Looping pass, then stop in PLAY of entry 3
    add(1,0,1,1,138, pk(0, 18'd0,     1,0,4'd0,1,0,10'h200)); // wrapped to 0
    add(0,0,1,1,  1, pk(1, 18'd95602, 0,0,4'd0,1,0,10'h200)); // C replays
    add(0,0,1,1,  1, pk(0, 18'd95602, 0,1,4'd0,1,0,10'h201));
    add(0,0,1,1, 56, pk(0, 18'd71633, 0,1,4'd3,1,0,10'h208)); // PLAY F
    add(0,1,1,1,  1, pk(0, 18'd71633, 0,0,4'd3,0,0,10'h000)); // stop
    add(1,1,0,1,  1, pk(0, 18'd71633, 0,0,4'd3,0,0,10'h000)); // start+stop stays IDLE
    add(1,0,0,1,  1, pk(0, 18'd71633, 0,0,4'd0,1,0,10'h200)); // restart at 0
    add(0,0,0,1,  1, pk(1, 18'd95602, 0,0,4'd0,1,0,10'h200)); // CFG C

    resetn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_state", act, 37'd0);
    resetn = 1'b1;
    repeat (2) tick();
    check("idle_after_reset", act, 37'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].st; stop = vecs[i].sp;
      loop_en = vecs[i].lp; cfg_ready = vecs[i].rdy;
      tick();
      start = 1'b0; stop = 1'b0;
      for (int k = 1; k < vecs[i].adv; k++) tick();
      check($sformatf("vec%0d", i), act, vecs[i].exp);
    end

    // Handshake stall: CFG held, nothing counts until accepted
    cfg_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("stall%0d", i), act, pk(1, 18'd95602, 0,0,4'd0,1,0,10'h200));
    end
    cfg_ready = 1'b1;
    te_cnt = 0;
    for (int i = 0; i < 40 && !(te_cnt > 0 && !tone_en); i++) begin
      tick();
      if (tone_en) te_cnt++;
    end
    check("play_len_after_stall", 37'(te_cnt), 37'd16);
    check("load_after_stall", act, pk(0, 18'd95602, 0,0,4'd1,1,0,10'h200));

    // Asynchronous reset mid-PLAY
    repeat (2) tick();
    check("pre_reset_play", act, pk(0, 18'd85178, 0,1,4'd1,1,0,10'h202));
    resetn = 1'b0;
    #2;
    check("async_reset", act, 37'd0);
    repeat (2) tick();
    check("reset_held", act, 37'd0);
    resetn = 1'b1;
    repeat (2) tick();
    check("idle_after_release", act, 37'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_after_release", act, pk(0, 18'd0, 0,0,4'd0,1,0,10'h200));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
